// File: rtl/sonar_uc_if.sv
// Control bus between the sonar sequencer and its environment
// (sensor interface, serial transmitter, interval timer, datapath).
interface sonar_uc_if;
  logic       ligar;
  logic       fim_medicao;
  logic       fim_transmissao;
  logic       tick_intervalo;
  logic       medir;
  logic       transmitir;
  logic [2:0] sel_char;
  logic       conta_posicao;
  logic       zera;
  logic       pronto;
  logic       erro_medida;
  logic [3:0] db_estado;

  // Environment side: drives the enables/completion pulses, watches the commands.
  modport master (
    output ligar, fim_medicao, fim_transmissao, tick_intervalo,
    input  medir, transmitir, sel_char, conta_posicao, zera, pronto,
           erro_medida, db_estado
  );

  // Sequencer side.
  modport slave (
    input  ligar, fim_medicao, fim_transmissao, tick_intervalo,
    output medir, transmitir, sel_char, conta_posicao, zera, pronto,
           erro_medida, db_estado
  );
endinterface

// File: rtl/sonar_uc.sv
// Sonar control unit: periodically triggers a distance measurement (with a
// timeout), then sends a frame of NUM_CHARS serial characters and advances
// the servo position. Command outputs are registered one-cycle pulses that
// coincide exactly with their state.
module sonar_uc #(
  parameter int NUM_CHARS = 8,
  parameter int TIMEOUT   = 3_000_000
) (
  input logic       clock,
  input logic       reset,
  sonar_uc_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_CHARS - 1);

  typedef enum logic [3:0] {
    INICIAL           = 4'd0,
    PREPARACAO        = 4'd1,
    MEDIR             = 4'd2,
    AGUARDA_MEDIDA    = 4'd3,
    TRANSMITE         = 4'd4,
    AGUARDA_TX        = 4'd5,
    PROX_CHAR         = 4'd6,
    FIM_FRAME         = 4'd7,
    AGUARDA_INTERVALO = 4'd8
  } state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [TW-1:0]   tcnt;
  logic            erro;
  logic            medir_r, transmitir_r, zera_r, pronto_r, conta_r;

  // Sequencer: pulse outputs are set on the transition into their state,
  // so each one is high for exactly the cycle spent in that state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= INICIAL;
      idx          <= '0;
      tcnt         <= '0;
      erro         <= 1'b0;
      medir_r      <= 1'b0;
      transmitir_r <= 1'b0;
      zera_r       <= 1'b0;
      pronto_r     <= 1'b0;
      conta_r      <= 1'b0;
    end else begin
      medir_r      <= 1'b0;
      transmitir_r <= 1'b0;
      zera_r       <= 1'b0;
      pronto_r     <= 1'b0;
      conta_r      <= 1'b0;
      case (state)
        INICIAL: begin
          if (bus.ligar) begin
            state  <= PREPARACAO;
            zera_r <= 1'b1;
          end
        end
        PREPARACAO: begin
          idx     <= '0;
          tcnt    <= '0;
          state   <= MEDIR;
          medir_r <= 1'b1;
        end
        MEDIR: state <= AGUARDA_MEDIDA;
        AGUARDA_MEDIDA: begin
          tcnt <= tcnt + TW'(1);
          // A valid measurement wins over a simultaneous timeout.
          if (bus.fim_medicao) begin
            erro         <= 1'b0;
            state        <= TRANSMITE;
            transmitir_r <= 1'b1;
          end else if (tcnt == T_LAST) begin
            erro         <= 1'b1;
            state        <= TRANSMITE;
            transmitir_r <= 1'b1;
          end
        end
        TRANSMITE: state <= AGUARDA_TX;
        AGUARDA_TX: begin
          if (bus.fim_transmissao) state <= PROX_CHAR;
        end
        PROX_CHAR: begin
          if (idx == IDX_LAST) begin
            state    <= FIM_FRAME;
            pronto_r <= 1'b1;
            conta_r  <= 1'b1;
          end else begin
            idx          <= idx + 3'd1;
            state        <= TRANSMITE;
            transmitir_r <= 1'b1;
          end
        end
        FIM_FRAME: state <= AGUARDA_INTERVALO;
        AGUARDA_INTERVALO: begin
          // Switching off takes priority over a coincident interval tick.
          if (!bus.ligar) begin
            state <= INICIAL;
          end else if (bus.tick_intervalo) begin
            state  <= PREPARACAO;
            zera_r <= 1'b1;
          end
        end
        default: state <= INICIAL;
      endcase
    end
  end

  assign bus.medir         = medir_r;
  assign bus.transmitir    = transmitir_r;
  assign bus.zera          = zera_r;
  assign bus.pronto        = pronto_r;
  assign bus.conta_posicao = conta_r;
  assign bus.erro_medida   = erro;
  assign bus.sel_char      = idx;
  assign bus.db_estado     = state;

endmodule

// File: tb/tb_sonar_uc.sv
// Randomized self-checking bench for sonar_uc (NUM_CHARS=8, TIMEOUT=20).
// The reference model predicts, per frame, the measurement outcome, the
// cycle at which each character command appears, the character order and
// the overall pulse totals.
module tb_sonar_uc;
  localparam int N  = 8;
  localparam int TO = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  sonar_uc_if bus ();

  sonar_uc #(.NUM_CHARS(N), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_medir = 0, n_tx = 0, n_pronto = 0, n_conta = 0, n_zera = 0;
  int exp_medir = 0, exp_tx = 0, exp_pronto = 0, exp_zera = 0;
  logic erro_model = 1'b0;
  int txk[N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and tally the command pulses seen there.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (bus.medir)         n_medir++;
    if (bus.transmitir)    n_tx++;
    if (bus.pronto)        n_pronto++;
    if (bus.conta_posicao) n_conta++;
    if (bus.zera)          n_zera++;
  endtask

  // One frame from the medir pulse onward. d: cycles after medir at which
  // fim_medicao is given (1..TO succeeds, anything else times out).
  // rst_char >= 0 aborts with reset while waiting on that character.
  task automatic run_frame(input int d, input int drop_char, input int rst_char);
    int   c, t, t0, rel;
    logic ok, exp_erro, stable;
    for (int i = 0; i < 60 && !bus.medir; i++) step();
    check_eq("medir_seen", bus.medir, 1);
    check_eq("db_medir", bus.db_estado, 2);
    c        = cyc;
    ok       = (d >= 1 && d <= TO);
    exp_erro = !ok;
    t0       = c + (ok ? d : TO) + 1;
    for (int i = 0; i < 40 && !bus.transmitir; i++) begin
      rel = cyc - c;
      if (rel == TO) check_eq("erro_hold", bus.erro_medida, erro_model);
      bus.fim_medicao     = ok && (rel == d);
      bus.fim_transmissao = ($urandom_range(0, 2) == 0);
      step();
      bus.fim_medicao     = 1'b0;
      bus.fim_transmissao = 1'b0;
    end
    check_eq("tx0_time", cyc - c, t0 - c);
    check_eq("erro_meas", bus.erro_medida, exp_erro);
    for (int k = 0; k < N; k++) begin
      t = cyc;
      stable = 1'b1;
      check_eq("sel", bus.sel_char, k);
      check_eq("db_tx", bus.db_estado, 4);
      if (k == drop_char) bus.ligar = 1'b0;
      if (k == rst_char) begin
        step();
        step();
        reset = 1'b0;
        bus.ligar = 1'b0;
        #1;
        check_eq("rst_db", bus.db_estado, 0);
        check_eq("rst_sel", bus.sel_char, 0);
        check_eq("rst_erro", bus.erro_medida, 0);
        erro_model = 1'b0;
        return;
      end
      for (int j = 0; j < txk[k]; j++) begin
        bus.fim_medicao = ($urandom_range(0, 2) == 0);
        step();
        bus.fim_medicao = 1'b0;
        if (bus.sel_char !== 3'(k)) stable = 1'b0;
      end
      bus.fim_transmissao = 1'b1;
      step();
      bus.fim_transmissao = 1'b0;
      if (bus.sel_char !== 3'(k)) stable = 1'b0;
      for (int i = 0; i < 10 && !(bus.transmitir || bus.pronto); i++) step();
      check_eq("sel_stable", stable, 1);
      check_eq("char_gap", cyc - t, txk[k] + 2);
      if (k == N - 1) begin
        check_eq("pronto", bus.pronto, 1);
        check_eq("conta", bus.conta_posicao, 1);
        check_eq("db_fim", bus.db_estado, 7);
        check_eq("erro_frame", bus.erro_medida, exp_erro);
      end else begin
        check_eq("tx_next", bus.transmitir, 1);
      end
    end
    erro_model = exp_erro;
  endtask

  task automatic set_txk(input bit rnd);
    for (int k = 0; k < N; k++) txk[k] = rnd ? int'($urandom_range(1, 6)) : 5;
  endtask

  // Called right after pronto: wait in the interval state, then tick.
  task automatic interval(input int w);
    step();
    for (int i = 0; i < w; i++) step();
    check_eq("db_intervalo", bus.db_estado, 8);
    bus.tick_intervalo = 1'b1;
    step();
    bus.tick_intervalo = 1'b0;
    check_eq("zera", bus.zera, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    bus.ligar = 1'b0;
    bus.fim_medicao = 1'b0;
    bus.fim_transmissao = 1'b0;
    bus.tick_intervalo = 1'b0;
    step();
    step();
    check_eq("rst_db0", bus.db_estado, 0);
    check_eq("rst_outs", {bus.medir, bus.transmitir, bus.zera, bus.pronto,
                          bus.conta_posicao, bus.erro_medida, bus.sel_char}, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("idle_db", bus.db_estado, 0);
    check_eq("idle_medir", n_medir, 0);

    // Nominal frame
    bus.ligar = 1'b1;
    set_txk(0);
    run_frame(10, -1, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    // Timeout, collision, timeout, then a good measurement clears the error
    interval(3);
    run_frame(0, -1, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    interval(0);
    run_frame(TO, -1, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    interval(1);
    run_frame(0, -1, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    interval(2);
    run_frame(7, -1, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      interval($urandom_range(0, 5));
      set_txk(1);
      run_frame($urandom_range(0, 22), -1, -1);
      exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    end

    // Drop ligar during char 3: frame completes, then back to INICIAL
    interval(1);
    set_txk(1);
    run_frame($urandom_range(1, 15), 3, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    step();
    step();
    check_eq("stop_db", bus.db_estado, 0);
    m0 = n_medir;
    for (int i = 0; i < 30; i++) begin
      bus.tick_intervalo = (i % 7 == 0);
      step();
    end
    bus.tick_intervalo = 1'b0;
    check_eq("stop_no_medir", n_medir, m0);

    // Restart; ligar=0 together with tick in the interval state
    bus.ligar = 1'b1;
    set_txk(1);
    run_frame(12, -1, -1);
    exp_medir++; exp_tx += N; exp_pronto++; exp_zera++;
    step();
    bus.ligar = 1'b0;
    bus.tick_intervalo = 1'b1;
    step();
    bus.tick_intervalo = 1'b0;
    check_eq("off_tick_db", bus.db_estado, 0);
    check_eq("off_tick_zera", bus.zera, 0);

    // Reset while waiting on char 5
    bus.ligar = 1'b1;
    set_txk(1);
    run_frame(9, -1, 5);
    exp_medir++; exp_tx += 6; exp_zera++;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check_eq("post_rst_db", bus.db_estado, 0);

    check_eq("total_medir", n_medir, exp_medir);
    check_eq("total_tx", n_tx, exp_tx);
    check_eq("total_pronto", n_pronto, exp_pronto);
    check_eq("total_conta", n_conta, exp_pronto);
    check_eq("total_zera", n_zera, exp_zera);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
